// File: rtl/blink_move_pkg.sv
// Shared encodings for the BlinkAndMove LED stage: mode select codes,
// FSM state type and the default LED count.
package blink_move_pkg;

  localparam int NB_LED_DEF = 4;

  localparam logic [1:0] MODE_ROT_L = 2'b00;
  localparam logic [1:0] MODE_ROT_R = 2'b01;
  localparam logic [1:0] MODE_PP    = 2'b10;
  localparam logic [1:0] MODE_BLINK = 2'b11;

  typedef enum logic [2:0] {
    S_ROT_L   = 3'd0,
    S_ROT_R   = 3'd1,
    S_PP_L    = 3'd2,
    S_PP_R    = 3'd3,
    S_BLK_ON  = 3'd4,
    S_BLK_OFF = 3'd5
  } state_t;

endpackage

// File: rtl/led_mover.sv
// LED pattern mover: each qualified tick (i_enable & i_valid) advances the
// pattern by the selected mode; o_wrap pulses on wrap, bounce or blink cycle.
module led_mover
  import blink_move_pkg::*;
#(
  parameter int NB_LED  = NB_LED_DEF,
  parameter int NB_MODE = 2
) (
  input  logic               clk,
  input  logic               i_rst,
  input  logic               i_enable,
  input  logic               i_valid,
  input  logic [NB_MODE-1:0] i_mode,
  output logic [NB_LED-1:0]  o_led,
  output logic               o_dir,
  output logic               o_wrap
);

  localparam logic [NB_LED-1:0] LED_LSB = {{(NB_LED-1){1'b0}}, 1'b1};
  localparam logic [NB_LED-1:0] LED_MSB = {1'b1, {(NB_LED-1){1'b0}}};
  localparam logic [NB_LED-1:0] LED_ALL = {NB_LED{1'b1}};
  localparam logic [NB_LED-1:0] LED_OFF = {NB_LED{1'b0}};

  // Packed entry record: {state, dir, pattern}
  localparam int ENTRY_W = NB_LED + 4;

  logic [NB_LED-1:0]  led_reg, led_next;
  logic               dir_reg, dir_next;
  logic               wrap_reg, wrap_next;
  logic [NB_MODE-1:0] mode_reg, mode_next;
  state_t             state_reg, state_next;

  logic               step;
  logic               led_onehot;
  logic [NB_LED-1:0]  led_shl, led_shr, led_rol, led_ror;
  logic [ENTRY_W-1:0] entry_new, entry_cur;

  function automatic logic [ENTRY_W-1:0] entry_of(input logic [NB_MODE-1:0] m);
    logic [ENTRY_W-1:0] e;
    if (m == NB_MODE'(MODE_ROT_R))
      e = {S_ROT_R, 1'b1, LED_MSB};
    else if (m == NB_MODE'(MODE_PP))
      e = {S_PP_L, 1'b0, LED_LSB};
    else if (m == NB_MODE'(MODE_BLINK))
      e = {S_BLK_ON, 1'b0, LED_ALL};
    else
      e = {S_ROT_L, 1'b0, LED_LSB};
    return e;
  endfunction

  assign step       = i_enable & i_valid;
  assign led_onehot = (led_reg != LED_OFF) && ((led_reg & (led_reg - LED_LSB)) == LED_OFF);
  assign led_shl    = {led_reg[NB_LED-2:0], 1'b0};
  assign led_shr    = {1'b0, led_reg[NB_LED-1:1]};
  assign led_rol    = {led_reg[NB_LED-2:0], led_reg[NB_LED-1]};
  assign led_ror    = {led_reg[0], led_reg[NB_LED-1:1]};
  assign entry_new  = entry_of(i_mode);
  assign entry_cur  = entry_of(mode_reg);

  always_ff @(posedge clk) begin
    if (!i_rst) begin
      led_reg   <= LED_LSB;
      dir_reg   <= 1'b0;
      wrap_reg  <= 1'b0;
      mode_reg  <= NB_MODE'(MODE_ROT_L);
      state_reg <= S_ROT_L;
    end else begin
      led_reg   <= led_next;
      dir_reg   <= dir_next;
      wrap_reg  <= wrap_next;
      mode_reg  <= mode_next;
      state_reg <= state_next;
    end
  end

  always_comb begin
    led_next   = led_reg;
    dir_next   = dir_reg;
    wrap_next  = 1'b0;
    mode_next  = mode_reg;
    state_next = state_reg;

    if (step) begin
      if (i_mode != mode_reg) begin
        mode_next  = i_mode;
        state_next = state_t'(entry_new[ENTRY_W-1 -: 3]);
        dir_next   = entry_new[NB_LED];
        led_next   = entry_new[NB_LED-1:0];
      end else begin
        case (state_reg)
          S_ROT_L, S_ROT_R, S_PP_L, S_PP_R: begin
            if (!led_onehot) begin
              // Corrupted pattern: restart the current mode cleanly.
              state_next = state_t'(entry_cur[ENTRY_W-1 -: 3]);
              dir_next   = entry_cur[NB_LED];
              led_next   = entry_cur[NB_LED-1:0];
            end else begin
              case (state_reg)
                S_ROT_L: begin
                  led_next  = led_rol;
                  wrap_next = led_reg[NB_LED-1];
                end
                S_ROT_R: begin
                  led_next  = led_ror;
                  wrap_next = led_reg[0];
                end
                S_PP_L: begin
                  led_next = led_shl;
                  if (led_shl[NB_LED-1]) begin
                    state_next = S_PP_R;
                    dir_next   = 1'b1;
                    wrap_next  = 1'b1;
                  end
                end
                default: begin
                  led_next = led_shr;
                  if (led_shr[0]) begin
                    state_next = S_PP_L;
                    dir_next   = 1'b0;
                    wrap_next  = 1'b1;
                  end
                end
              endcase
            end
          end
          S_BLK_ON: begin
            led_next   = LED_OFF;
            state_next = S_BLK_OFF;
          end
          S_BLK_OFF: begin
            led_next   = LED_ALL;
            state_next = S_BLK_ON;
            wrap_next  = 1'b1;
          end
          default: begin
            state_next = state_t'(entry_cur[ENTRY_W-1 -: 3]);
            dir_next   = entry_cur[NB_LED];
            led_next   = entry_cur[NB_LED-1:0];
          end
        endcase
      end
    end
  end

  assign o_led  = led_reg;
  assign o_dir  = dir_reg;
  assign o_wrap = wrap_reg;

endmodule

// File: doc/led_mover.md
Name: led_mover

Overview:
- Stage directly downstream of the BlinkAndMove tick counter. It consumes the counter's single-cycle `o_valid` tick and drives the board LED pattern.
- Each qualified tick advances an LED pattern according to a selected mode: rotate left, rotate right, ping-pong or blink-all.
- Output goes straight to the LED pins. A one-cycle wrap pulse is available for chaining or debug.

Parameters:
- NB_LED, 4, number of LEDs / pattern width; legal values ≥2.
- NB_MODE, 2, width of the mode select input.

Ports:
- clk  input  1  system clock, rising edge.
- i_rst  input  1  synchronous active-low reset; sampled on rising clk; 0 = reset.
- i_enable  input  1  1 = pattern may advance; 0 = freeze.
- i_valid  input  1  step tick from the counter; nominally 1 cycle wide.
- i_mode  input  NB_MODE  00 rotate left, 01 rotate right, 10 ping-pong, 11 blink.
- o_led  output  NB_LED  registered LED pattern.
- o_dir  output  1  current motion direction: 0 = toward MSB (left), 1 = toward LSB (right).
- o_wrap  output  1  one-cycle pulse on wrap, bounce or blink-cycle completion.

Behaviour:
- Reset: i_rst==0 at a rising clk forces the following, overriding all other inputs, including mid-step:
  - o_led = 1 (only LSB lit), o_dir = 0, o_wrap = 0.
  - Internal mode register = 00, state = S_ROT_L.
- Step qualifier: step = i_enable & i_valid, sampled at a rising edge. o_led, o_dir and o_wrap change on that same edge (1-cycle registered latency from the tick).
- No step: all registers hold. o_wrap = 0 on every non-step cycle, so it is never high two consecutive cycles unless step is.
- i_valid held high for k cycles with i_enable=1 = k steps; no edge detection.
- Mode change: i_mode is sampled only on step cycles.
  - If the sampled i_mode ≠ the stored mode, that step is a mode entry: load the entry pattern, update the mode/state, do not shift, o_wrap = 0.
  - Entry patterns:
    - rotate left: o_led = 0..01, o_dir = 0.
    - rotate right: o_led = 10..0, o_dir = 1.
    - ping-pong: o_led = 0..01, o_dir = 0.
    - blink: o_led = all ones, o_dir = 0.
- FSM states: S_ROT_L, S_ROT_R, S_PP_L, S_PP_R, S_BLK_ON, S_BLK_OFF.
- S_ROT_L:
  - o_led <= {o_led[NB_LED-2:0], o_led[NB_LED-1]}.
  - o_wrap = 1 when old o_led[NB_LED-1] == 1.
- S_ROT_R:
  - o_led <= {o_led[0], o_led[NB_LED-1:1]}.
  - o_wrap = 1 when old o_led[0] == 1.
- S_PP_L:
  - Shift left, no rotate.
  - If the new pattern has its MSB set: go to S_PP_R, o_dir = 1, o_wrap = 1.
- S_PP_R:
  - Shift right.
  - If the new pattern has its LSB set: go to S_PP_L, o_dir = 0, o_wrap = 1.
- S_BLK_ON / S_BLK_OFF:
  - o_led toggles between all ones and all zeros; the state follows.
  - o_wrap = 1 on the OFF→ON step.
- NB_LED=2 ping-pong: 01→10 (bounce) →01 (bounce); o_wrap is asserted on every step.
- Pattern integrity: in rotate and ping-pong modes o_led is always one-hot. If a non-one-hot value is ever detected in those states, the next step reloads the mode's entry pattern.
- Simultaneous i_enable=0 and i_valid=1: the tick is dropped, not queued.

Decomposition:
- Package blink_move_pkg:
  - Mode encodings (MODE_ROT_L=2'b00, MODE_ROT_R=2'b01, MODE_PP=2'b10, MODE_BLINK=2'b11).
  - FSM state localparams.
  - Default NB_LED.
- No sub-module: a single FSM plus pattern register is natural. The next-pattern computation may be a function in the package for reuse by the bench model.

Test Plan (NB_LED=4):
- Reset, then rotate left: i_rst=0 for 2 cycles, then i_rst=1, i_mode=00, 5 ticks → o_led 0001→0010→0100→1000→0001→0010; o_wrap high only on the 4th step.
- Mode change to ping-pong: from o_led=0100 in rotate left, tick with i_mode=10 → 0001 with no shift. Further ticks → 0010, 0100, 1000 (o_dir=1, o_wrap=1), 0100, 0010, 0001 (o_dir=0, o_wrap=1).
- Blink: i_mode=11, ticks → 1111 (entry), 0000, 1111 (o_wrap=1), 0000.
- Enable gating: i_enable=0 with 3 ticks → o_led unchanged, o_wrap=0. Re-enable, 1 tick → exactly one step.
- Mid-operation reset: in ping-pong at 1000 with o_dir=1, assert i_rst=0 coincident with a tick → next cycle o_led=0001, o_dir=0, o_wrap=0, mode=rotate left.
- Held valid: i_valid high for 3 consecutive cycles in rotate right from 1000 → 0100, 0010, 0001 on consecutive edges.
